tx_frame_arb: RTL and testbench
===============================

TX_FRAME_ARB -- requirements
Module: tx_frame_arb

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 1024, which is the watchdog limit in accepted beats per frame (legal range 2..65535).
REQ-002 SHALL have port tx_user_clk_i, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port tx_user_rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port arb_en_i, input, 1 bit: enables new grants; when low, the frame in progress still completes.
REQ-005 SHALL have ports s0_data_i [31:0], s0_vldb_i [1:0], s0_valid_i, s0_last_i, s0_user_i [0:0] (inputs) and s0_ready_o (output): source 0 stream (PRBS generator).
REQ-006 SHALL have ports s1_data_i, s1_vldb_i, s1_valid_i, s1_last_i, s1_user_i and s1_ready_o with the same widths as REQ-005: source 1 stream.
REQ-007 SHALL have ports m_data_o [31:0], m_vldb_o [1:0], m_valid_o, m_last_o, m_user_o [0:0] (outputs) and m_ready_i (input): stream to the MAC TX user interface.
REQ-008 SHALL have outputs frm_cnt0_o [15:0] and frm_cnt1_o [15:0]: count of frames completed on m per source.
REQ-009 SHALL have output trunc_cnt_o [15:0]: count of watchdog-truncated frames.
REQ-010 SHALL have output busy_o, 1 bit: high when the state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, BUSY and FLUSH, plus a registered grant index gnt (0 or 1) and a registered priority pointer pri.
REQ-012 In IDLE with arb_en_i=1 and at least one sX_valid_i high: SHALL set gnt to the requesting source; if both request, SHALL pick the one equal to pri; next state is BUSY.
REQ-013 In IDLE: m_valid_o=0 and s0_ready_o=s1_ready_o=0, giving exactly one bubble cycle before each frame.
REQ-014 In BUSY: m_* SHALL be a combinational pass-through of the granted source with zero latency (m_valid_o=sG_valid_i, sG_ready_o=m_ready_i); the non-granted ready SHALL be 0.
REQ-015 A beat SHALL be accepted when m_valid_o & m_ready_i; a beat counter (16-bit) SHALL increment on each accepted beat in BUSY.
REQ-016 On an accepted beat with sG_last_i=1 in BUSY: next state is IDLE, the beat counter clears, pri is set to the other source (~gnt), and frm_cntG increments.
REQ-017 On an accepted beat where the counter equals MAX_BEATS-1 and sG_last_i=0: SHALL force m_last_o=1 and m_user_o=1 on that beat, increment frm_cntG and trunc_cnt, and go to FLUSH.
REQ-018 In FLUSH: sG_ready_o=1, m_valid_o=0, and source beats are discarded; on a discarded beat with sG_last_i=1, next state is IDLE and pri is set to ~gnt.
REQ-019 A frame of exactly MAX_BEATS beats whose last beat carries sG_last_i=1 SHALL complete normally, with no truncation.
REQ-020 If arb_en_i falls during BUSY or FLUSH, the current frame SHALL finish; the block SHALL then remain in IDLE.
REQ-021 All 16-bit counters SHALL wrap from 0xFFFF to 0x0000.
REQ-022 m_data_o, m_vldb_o and m_last_o SHALL be 0 whenever m_valid_o=0.
REQ-023 Source-side valid/data stability is the sources' responsibility; the block SHALL NOT register datapath beats.

Reset
REQ-024 On tx_user_rst_n_i=0 at a clock edge: state=IDLE, gnt=0, pri=0, and the beat, frame and trunc counters =0.
REQ-025 During and immediately after reset: m_valid_o=0, s0_ready_o=s1_ready_o=0, busy_o=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without emitting m_last_o; sources are reset alongside the arbiter.

Structure
REQ-027 A shared package/header tx_arb_pkg SHALL hold the state encodings, the stream widths (DATA_W=32, VLDB_W=2, USER_W=1) and the counter width (16).
REQ-028 SHALL use one sub-module, tx_arb_rr: the two-request round-robin picker (inputs req[1:0] and pri; output gnt_nxt).

Verification
REQ-029 Only s0 valid, with 4-beat frames back-to-back, m_ready_i=1 -> each frame on m takes 5 cycles (1 bubble plus 4 beats); frm_cnt0=N after N frames.
REQ-030 Both sources continuously valid, 3-beat frames -> frames alternate s0,s1,s0,s1 starting with s0 after reset; frm_cnt0=frm_cnt1 after each pair.
REQ-031 MAX_BEATS=8, s1 sends a 12-beat frame -> m shows 8 beats with the 8th having last=1, user=1; 4 beats are absorbed in FLUSH; trunc_cnt=1; the next grant goes to s0.
REQ-032 MAX_BEATS=8, an 8-beat frame with last on beat 8 -> m_user_o=0 and trunc_cnt stays 0.
REQ-033 m_ready_i toggled randomly 50% -> the beat sequence on m equals the source sequence, and no beat is accepted while ready=0.
REQ-034 arb_en_i deasserted at beat 2 of 5, and separately reset pulsed at beat 2 -> the first case completes the frame then idles; the second case drops immediately to the reset values of REQ-024/025.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared types and widths for the two-source TX frame arbiter.
// Stream beat layout, FSM state encoding and counter width live here.
package tx_arb_pkg;

    localparam int DATA_W = 32;
    localparam int VLDB_W = 2;
    localparam int USER_W = 1;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [VLDB_W-1:0] vldb;
        logic              last;
        logic [USER_W-1:0] user;
    } beat_t;

endpackage

// File: rtl/tx_frame_arb_if.sv
// One valid/ready stream leg (source or MAC side) of the TX frame arbiter.
// master drives the beat and valid, slave returns ready.
interface tx_frame_arb_if;
    import tx_arb_pkg::*;

    logic [DATA_W-1:0] data;
    logic [VLDB_W-1:0] vldb;
    logic              valid;
    logic              last;
    logic [USER_W-1:0] user;
    logic              ready;

    modport master (output data, vldb, valid, last, user, input ready);
    modport slave  (input data, vldb, valid, last, user, output ready);

endinterface

// File: rtl/tx_arb_rr.sv
// Two-request round-robin picker: a lone requester wins, a tie goes to pri.
// Purely combinational, no backpressure of its own.
module tx_arb_rr
    import tx_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pri,
    output logic       gnt_nxt
);

    always_comb begin
        gnt_nxt = pri;
        if (req == 2'b01) begin
            gnt_nxt = 1'b0;
        end else if (req == 2'b10) begin
            gnt_nxt = 1'b1;
        end
    end

endmodule

// File: rtl/tx_frame_arb.sv
// Frame-atomic round-robin mux of two sources onto the MAC TX stream; one idle cycle per grant,
// then zero-latency pass-through with m_ready_i steering the granted source; over-long frames are cut and flushed.
module tx_frame_arb
    import tx_arb_pkg::*;
#(
    parameter int MAX_BEATS = 1024
) (
    input  logic              tx_user_clk_i,
    input  logic              tx_user_rst_n_i,
    input  logic              arb_en_i,

    input  logic [DATA_W-1:0] s0_data_i,
    input  logic [VLDB_W-1:0] s0_vldb_i,
    input  logic              s0_valid_i,
    input  logic              s0_last_i,
    input  logic [USER_W-1:0] s0_user_i,
    output logic              s0_ready_o,

    input  logic [DATA_W-1:0] s1_data_i,
    input  logic [VLDB_W-1:0] s1_vldb_i,
    input  logic              s1_valid_i,
    input  logic              s1_last_i,
    input  logic [USER_W-1:0] s1_user_i,
    output logic              s1_ready_o,

    output logic [DATA_W-1:0] m_data_o,
    output logic [VLDB_W-1:0] m_vldb_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    output logic [USER_W-1:0] m_user_o,
    input  logic              m_ready_i,

    output logic [CNT_W-1:0]  frm_cnt0_o,
    output logic [CNT_W-1:0]  frm_cnt1_o,
    output logic [CNT_W-1:0]  trunc_cnt_o,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

    arb_state_t       state;
    logic             gnt;
    logic             pri;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] frm_cnt0;
    logic [CNT_W-1:0] frm_cnt1;
    logic [CNT_W-1:0] trunc_cnt;

    beat_t s0_beat;
    beat_t s1_beat;
    beat_t sg_beat;
    logic  sg_valid;
    logic  gnt_nxt;
    logic  accept;
    logic  discard;
    logic  trunc_hit;

    assign s0_beat  = {s0_data_i, s0_vldb_i, s0_last_i, s0_user_i};
    assign s1_beat  = {s1_data_i, s1_vldb_i, s1_last_i, s1_user_i};
    assign sg_beat  = gnt ? s1_beat : s0_beat;
    assign sg_valid = gnt ? s1_valid_i : s0_valid_i;

    // The beat counter holds beats already accepted, so it reads MAX_BEATS-1 on the final allowed beat.
    assign trunc_hit = (beat_cnt == LAST_IDX) && !sg_beat.last;
    assign accept    = (state == ST_BUSY) && sg_valid && m_ready_i;
    assign discard   = (state == ST_FLUSH) && sg_valid;

    tx_arb_rr u_rr (
        .req     ({s1_valid_i, s0_valid_i}),
        .pri     (pri),
        .gnt_nxt (gnt_nxt)
    );

    always_comb begin
        m_valid_o  = 1'b0;
        m_data_o   = '0;
        m_vldb_o   = '0;
        m_last_o   = 1'b0;
        m_user_o   = '0;
        s0_ready_o = 1'b0;
        s1_ready_o = 1'b0;
        if (state == ST_BUSY) begin
            m_valid_o = sg_valid;
            if (sg_valid) begin
                m_data_o    = sg_beat.dat;
                m_vldb_o    = sg_beat.vldb;
                m_last_o    = sg_beat.last | trunc_hit;
                m_user_o    = sg_beat.user;
                m_user_o[0] = sg_beat.user[0] | trunc_hit;
            end
            s0_ready_o = !gnt && m_ready_i;
            s1_ready_o = gnt && m_ready_i;
        end else if (state == ST_FLUSH) begin
            // Swallow the tail of a cut frame without presenting anything to the MAC.
            s0_ready_o = !gnt;
            s1_ready_o = gnt;
        end
    end

    always_ff @(posedge tx_user_clk_i) begin
        if (!tx_user_rst_n_i) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            gnt       <= 1'b0;
            pri       <= 1'b0;
            beat_cnt  <= '0;
            frm_cnt0  <= '0;
            frm_cnt1  <= '0;
            trunc_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_en_i && (s0_valid_i || s1_valid_i)) begin
                        gnt   <= gnt_nxt;
                        state <= ST_BUSY;
                        busy  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept) begin
                        if (sg_beat.last || trunc_hit) begin
                            beat_cnt <= '0;
                            if (gnt) begin
                                frm_cnt1 <= frm_cnt1 + CNT_W'(1);
                            end else begin
                                frm_cnt0 <= frm_cnt0 + CNT_W'(1);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                        if (sg_beat.last) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            pri   <= ~gnt;
                        end else if (trunc_hit) begin
                            state     <= ST_FLUSH;
                            trunc_cnt <= trunc_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (discard && sg_beat.last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        pri   <= ~gnt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign frm_cnt0_o  = frm_cnt0;
    assign frm_cnt1_o  = frm_cnt1;
    assign trunc_cnt_o = trunc_cnt;
    assign busy_o      = busy;

endmodule

// File: tb/tb_tx_frame_arb.sv
// Bench for tx_frame_arb: frame queues per source, a frame-rule model of what each source beat
// must look like on the MAC side, directed scenarios followed by a randomized mix.
module tb_tx_frame_arb;
    import tx_arb_pkg::*;

    localparam int MB = 8;

    typedef struct {
        logic [DATA_W-1:0] dat;
        logic [VLDB_W-1:0] vldb;
        logic              user;
        int                idx;
        int                len;
    } tb_beat_t;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             arb_en = 1'b0;
    logic [CNT_W-1:0] frm_cnt0;
    logic [CNT_W-1:0] frm_cnt1;
    logic [CNT_W-1:0] trunc_cnt;
    logic             busy;

    tx_frame_arb_if s0_if ();
    tx_frame_arb_if s1_if ();
    tx_frame_arb_if m_if ();

    always #5 clk = ~clk;

    tx_frame_arb #(.MAX_BEATS(MB)) dut (
        .tx_user_clk_i   (clk),
        .tx_user_rst_n_i (rst_n),
        .arb_en_i        (arb_en),
        .s0_data_i       (s0_if.data),
        .s0_vldb_i       (s0_if.vldb),
        .s0_valid_i      (s0_if.valid),
        .s0_last_i       (s0_if.last),
        .s0_user_i       (s0_if.user),
        .s0_ready_o      (s0_if.ready),
        .s1_data_i       (s1_if.data),
        .s1_vldb_i       (s1_if.vldb),
        .s1_valid_i      (s1_if.valid),
        .s1_last_i       (s1_if.last),
        .s1_user_i       (s1_if.user),
        .s1_ready_o      (s1_if.ready),
        .m_data_o        (m_if.data),
        .m_vldb_o        (m_if.vldb),
        .m_valid_o       (m_if.valid),
        .m_last_o        (m_if.last),
        .m_user_o        (m_if.user),
        .m_ready_i       (m_if.ready),
        .frm_cnt0_o      (frm_cnt0),
        .frm_cnt1_o      (frm_cnt1),
        .trunc_cnt_o     (trunc_cnt),
        .busy_o          (busy)
    );

    int               n_checks = 0;
    int               n_errors = 0;
    tb_beat_t         q0[$];
    tb_beat_t         q1[$];
    logic             v0 = 1'b0;
    logic             v1 = 1'b0;
    int               gap_pct = 0;
    bit               rand_rdy = 1'b0;
    logic [CNT_W-1:0] exp_frm0 = '0;
    logic [CNT_W-1:0] exp_frm1 = '0;
    logic [CNT_W-1:0] exp_trunc = '0;
    int               order_q[$];
    int               last_cyc[$];
    int               cyc = 0;
    int               pops0 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_frame(input int src, input int len, input bit rnd_user);
        tb_beat_t b;
        for (int i = 0; i < len; i++) begin
            b.dat  = $urandom;
            b.vldb = VLDB_W'($urandom);
            b.user = rnd_user ? 1'($urandom) : 1'b0;
            b.idx  = i;
            b.len  = len;
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    task automatic drive_src();
        if (!v0 && q0.size() > 0 && $urandom_range(0, 99) >= gap_pct) v0 = 1'b1;
        if (!v1 && q1.size() > 0 && $urandom_range(0, 99) >= gap_pct) v1 = 1'b1;
        s0_if.valid = v0;
        if (v0) begin
            s0_if.data = q0[0].dat;
            s0_if.vldb = q0[0].vldb;
            s0_if.last = (q0[0].idx == q0[0].len - 1);
            s0_if.user = q0[0].user;
        end else begin
            s0_if.data = $urandom;
            s0_if.vldb = VLDB_W'($urandom);
            s0_if.last = 1'($urandom);
            s0_if.user = USER_W'($urandom);
        end
        s1_if.valid = v1;
        if (v1) begin
            s1_if.data = q1[0].dat;
            s1_if.vldb = q1[0].vldb;
            s1_if.last = (q1[0].idx == q1[0].len - 1);
            s1_if.user = q1[0].user;
        end else begin
            s1_if.data = $urandom;
            s1_if.vldb = VLDB_W'($urandom);
            s1_if.last = 1'($urandom);
            s1_if.user = USER_W'($urandom);
        end
    endtask

    // A source beat leaving at index < MB must appear on m in the same cycle; later ones are dropped.
    task automatic consume(input int src, input logic mf);
        tb_beat_t b;
        int       keep;
        if (src == 0) begin
            b = q0.pop_front();
            v0 = 1'b0;
            pops0++;
        end else begin
            b = q1.pop_front();
            v1 = 1'b0;
        end
        if (b.idx == 0) order_q.push_back(src);
        keep = (b.len < MB) ? b.len : MB;
        if (b.idx < MB) begin
            chk("beat_accept", 64'(mf), 64'd1);
            chk("busy_on_beat", 64'(busy), 64'd1);
            if (mf) begin
                chk("m_data", 64'(m_if.data), 64'(b.dat));
                chk("m_vldb", 64'(m_if.vldb), 64'(b.vldb));
                chk("m_last", 64'(m_if.last), 64'((b.idx == b.len - 1) || (b.idx == MB - 1)));
                chk("m_user", 64'(m_if.user), 64'(b.user | (b.len > MB && b.idx == MB - 1)));
            end
            if (b.idx == keep - 1) begin
                if (src == 0) exp_frm0 = exp_frm0 + CNT_W'(1);
                else          exp_frm1 = exp_frm1 + CNT_W'(1);
            end
            if (b.len > MB && b.idx == MB - 1) exp_trunc = exp_trunc + CNT_W'(1);
        end else begin
            chk("flush_no_m_beat", 64'(mf), 64'd0);
        end
    endtask

    task automatic check_cycle();
        logic f0;
        logic f1;
        logic mf;
        if (!rst_n) return;
        f0 = s0_if.valid & s0_if.ready;
        f1 = s1_if.valid & s1_if.ready;
        mf = m_if.valid & m_if.ready;
        chk("frm_cnt0", 64'(frm_cnt0), 64'(exp_frm0));
        chk("frm_cnt1", 64'(frm_cnt1), 64'(exp_frm1));
        chk("trunc_cnt", 64'(trunc_cnt), 64'(exp_trunc));
        if (!m_if.valid) chk("idle_zero", 64'({m_if.data, m_if.vldb, m_if.last}), 64'd0);
        chk("dual_fire", 64'(f0 & f1), 64'd0);
        if (f0)      consume(0, mf);
        else if (f1) consume(1, mf);
        else         chk("orphan_m_beat", 64'(mf), 64'd0);
        if (mf && m_if.last) last_cyc.push_back(cyc);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        m_if.ready = rand_rdy ? 1'($urandom) : 1'b1;
        drive_src();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        v0 = 1'b0;
        v1 = 1'b0;
        drive_src();
        m_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_if.valid), 64'd0);
        chk("rst_s0_ready", 64'(s0_if.ready), 64'd0);
        chk("rst_s1_ready", 64'(s1_if.ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_counts", 64'({frm_cnt0, frm_cnt1, trunc_cnt}), 64'd0);
        exp_frm0 = '0;
        exp_frm1 = '0;
        exp_trunc = '0;
        order_q.delete();
        last_cyc.delete();
        pops0 = 0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_m_valid", 64'(m_if.valid), 64'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 3000) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n >= 3000), 64'd0);
        repeat (2) cycle();
    endtask

    task automatic wait_pops0(input int target, input string tag);
        int n = 0;
        while (pops0 < target && n < 200) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n >= 200), 64'd0);
    endtask

    initial begin
        m_if.ready  = 1'b1;
        s0_if.valid = 1'b0;
        s1_if.valid = 1'b0;
        arb_en      = 1'b1;

        // Lone source, 4-beat frames back to back: one frame every 5 cycles.
        do_reset();
        for (int i = 0; i < 5; i++) add_frame(0, 4, 1'b0);
        drain("seq4");
        chk("seq4_frames", 64'(frm_cnt0), 64'd5);
        chk("seq4_last_count", 64'(last_cyc.size()), 64'd5);
        for (int i = 1; i < last_cyc.size(); i++)
            chk("seq4_period", 64'(last_cyc[i] - last_cyc[i-1]), 64'd5);

        // Both sources always ready with 3-beat frames: strict alternation from s0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_frame(0, 3, 1'b0);
            add_frame(1, 3, 1'b0);
        end
        drain("alt");
        chk("alt_frames", 64'(order_q.size()), 64'd8);
        for (int i = 0; i < order_q.size(); i++) chk("alt_order", 64'(order_q[i]), 64'(i % 2));
        chk("alt_balance", 64'({frm_cnt0, frm_cnt1}), 64'({16'd4, 16'd4}));

        // Over-long s1 frame is cut at 8, tail flushed, s0 granted next.
        do_reset();
        add_frame(0, 3, 1'b0);
        drain("pre_trunc");
        add_frame(1, 12, 1'b0);
        add_frame(1, 3, 1'b0);
        repeat (5) cycle();
        add_frame(0, 3, 1'b0);
        drain("trunc");
        chk("trunc_total", 64'(trunc_cnt), 64'd1);
        chk("trunc_order_len", 64'(order_q.size()), 64'd4);
        for (int i = 0; i < order_q.size(); i++) chk("trunc_order", 64'(order_q[i]), 64'(i % 2));

        // Exactly MAX_BEATS with last on the final beat is a normal frame.
        do_reset();
        add_frame(0, MB, 1'b0);
        drain("exact");
        chk("exact_trunc", 64'(trunc_cnt), 64'd0);
        chk("exact_frames", 64'(frm_cnt0), 64'd1);

        // Enable dropped mid-frame: frame completes, next one is held off.
        do_reset();
        add_frame(0, 5, 1'b0);
        add_frame(0, 5, 1'b0);
        wait_pops0(2, "en_wait");
        arb_en = 1'b0;
        repeat (20) cycle();
        chk("en_off_busy", 64'(busy), 64'd0);
        chk("en_off_frames", 64'(frm_cnt0), 64'd1);
        chk("en_off_pending", 64'(q0.size()), 64'd5);
        arb_en = 1'b1;
        drain("en_on");
        chk("en_on_frames", 64'(frm_cnt0), 64'd2);

        // Reset mid-frame: frame is abandoned with no last on m.
        do_reset();
        add_frame(0, 5, 1'b0);
        wait_pops0(2, "rst_wait");
        chk("rst_mid_no_last", 64'(last_cyc.size()), 64'd0);
        do_reset();

        // Randomized mix: lengths 1..12, source gaps, 50% MAC backpressure.
        gap_pct  = 30;
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) add_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, 12)), 1'b1);
        drain("rand");
        chk("rand_frames", 64'(frm_cnt0 + frm_cnt1), 64'd40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
